// File: rtl/audio_front_end.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_front_end : boxcar decimator, DC removal, 8-bit saturation and      |
// |                   overrun-safe record gating ahead of the sample recorder |
// | Revision 1.0    : initial release                                         |
// +--------------------------------------------------------------------------+
module audio_front_end #(
   parameter int IN_WIDTH    = 12,
   parameter int DECIM_LOG2  = 2,
   parameter int DC_EN       = 1,
   parameter int DC_SHIFT    = 6,
   parameter int MAX_SAMPLES = 18000
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [IN_WIDTH-1:0] mic_data_in,
   input  logic                mic_valid_in,
   input  logic                record_req_in,
   output logic [7:0]          audio_out,
   output logic                audio_valid_out,
   output logic                record_out,
   output logic                full_out
);
   localparam int C_ACC_W = IN_WIDTH + DECIM_LOG2;
   localparam int C_DC_W  = IN_WIDTH + 1 + DC_SHIFT;
   localparam int C_Y_W   = IN_WIDTH + 2;
   localparam int C_CNT_W = $clog2(MAX_SAMPLES + 1);
   localparam logic [IN_WIDTH:0]        C_HALF    = (IN_WIDTH + 1)'(1) << (IN_WIDTH - 1);
   localparam logic signed [C_Y_W-1:0]  C_SAT_MAX = C_Y_W'(127);
   localparam logic signed [C_Y_W-1:0]  C_SAT_MIN = C_Y_W'(-128);
   localparam logic [C_CNT_W-1:0]       C_CNT_MAX = C_CNT_W'(MAX_SAMPLES);

   logic [C_ACC_W-1:0]         r_acc;
   logic [C_ACC_W-1:0]         w_sum;
   logic [DECIM_LOG2-1:0]      r_phase;
   logic                       w_frame_done;
   logic [IN_WIDTH-1:0]        w_avg;
   logic signed [IN_WIDTH:0]   w_centered;
   logic signed [IN_WIDTH:0]   r_s1_centered;
   logic                       r_s1_valid;
   logic signed [IN_WIDTH:0]   w_dc;
   logic signed [C_Y_W-1:0]    w_y;
   logic signed [C_Y_W-1:0]    w_y_sh;
   logic [7:0]                 w_sat;
   logic [7:0]                 r_audio;
   logic                       r_audio_valid;
   logic [C_CNT_W-1:0]         r_count;
   logic [C_CNT_W-1:0]         w_count_next;
   logic                       w_count_inc;
   logic                       w_count_last;
   logic                       r_record;
   logic                       r_full;

   // The sample arriving with the frame's final strobe is folded into w_sum.
   assign w_sum        = r_acc + C_ACC_W'(mic_data_in);
   assign w_frame_done = mic_valid_in && (&r_phase);
   assign w_avg        = w_sum[C_ACC_W-1:DECIM_LOG2];
   assign w_centered   = {1'b0, w_avg} - C_HALF;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_acc   <= '0;
         r_phase <= '0;
      end else if (mic_valid_in) begin
         r_phase <= r_phase + DECIM_LOG2'(1);
         r_acc   <= w_frame_done ? '0 : w_sum;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_s1_valid    <= 1'b0;
         r_s1_centered <= '0;
      end else begin
         r_s1_valid <= w_frame_done;
         if (w_frame_done)
            r_s1_centered <= w_centered;
      end
   end

   generate
      if (DC_EN != 0) begin : g_dc_on
         logic signed [C_DC_W-1:0] r_dc_acc;
         always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in)
               r_dc_acc <= '0;
            else if (r_s1_valid)
               r_dc_acc <= r_dc_acc + C_DC_W'(w_y);
         end
         // Dropping the low DC_SHIFT bits is the arithmetic shift; the result fits IN_WIDTH+1.
         assign w_dc = r_dc_acc[C_DC_W-1:DC_SHIFT];
      end else begin : g_dc_off
         assign w_dc = '0;
      end
   endgenerate

   assign w_y    = C_Y_W'(r_s1_centered) - C_Y_W'(w_dc);
   assign w_y_sh = w_y >>> (IN_WIDTH - 8);

   always_comb begin
      w_sat = w_y_sh[7:0];
      if (w_y_sh > C_SAT_MAX)
         w_sat = 8'h7F;
      else if (w_y_sh < C_SAT_MIN)
         w_sat = 8'h80;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_audio       <= '0;
         r_audio_valid <= 1'b0;
      end else begin
         r_audio_valid <= r_s1_valid;
         if (r_s1_valid)
            r_audio <= w_sat;
      end
   end

   // record_out is already low once full, so the counter stops at MAX_SAMPLES.
   assign w_count_inc  = r_audio_valid && r_record;
   assign w_count_next = r_count + C_CNT_W'(1);
   assign w_count_last = w_count_inc && (w_count_next == C_CNT_MAX);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_count  <= '0;
         r_full   <= 1'b0;
         r_record <= 1'b0;
      end else begin
         if (w_count_inc)
            r_count <= w_count_next;
         if (w_count_last)
            r_full <= 1'b1;
         r_record <= record_req_in && !r_full && !w_count_last;
      end
   end

   assign audio_out       = r_audio;
   assign audio_valid_out = r_audio_valid;
   assign record_out      = r_record;
   assign full_out        = r_full;
endmodule
`default_nettype wire

// File: tb/tb_audio_front_end.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_audio_front_end : scoreboard bench, one DUT without and one with DC    |
// |                      removal, both sharing stimulus, MAX_SAMPLES = 5      |
// | Revision 1.0       : initial release                                      |
// +--------------------------------------------------------------------------+
module tb_audio_front_end;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [11:0] mic_data_in;
   logic        mic_valid_in;
   logic        record_req_in;
   logic [7:0]  a0, a1;
   logic        v0, v1, r0, r1, f0, f1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fsum  = 0;
   int dc_m  = 0;

   typedef struct { int val; int cyc; } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   audio_front_end #(.IN_WIDTH(12), .DECIM_LOG2(2), .DC_EN(0), .DC_SHIFT(6), .MAX_SAMPLES(5)) dut0 (
      .clk_in(clk_in), .rst_in(rst_in), .mic_data_in(mic_data_in), .mic_valid_in(mic_valid_in),
      .record_req_in(record_req_in), .audio_out(a0), .audio_valid_out(v0), .record_out(r0), .full_out(f0));

   audio_front_end #(.IN_WIDTH(12), .DECIM_LOG2(2), .DC_EN(1), .DC_SHIFT(6), .MAX_SAMPLES(5)) dut1 (
      .clk_in(clk_in), .rst_in(rst_in), .mic_data_in(mic_data_in), .mic_valid_in(mic_valid_in),
      .record_req_in(record_req_in), .audio_out(a1), .audio_valid_out(v1), .record_out(r1), .full_out(f1));

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk_in) begin
      if (v0) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL dut0 unexpected strobe: audio=%0d cycle=%0d", $signed(a0), cyc);
         end else begin
            e0 = q0.pop_front();
            check("dut0 audio", $signed(a0), e0.val);
            check("dut0 strobe cycle", cyc, e0.cyc);
         end
      end
   end

   always @(negedge clk_in) begin
      if (v1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL dut1 unexpected strobe: audio=%0d cycle=%0d", $signed(a1), cyc);
         end else begin
            e1 = q1.pop_front();
            check("dut1 audio", $signed(a1), e1.val);
            check("dut1 strobe cycle", cyc, e1.cyc);
         end
      end
   end

   // Reference for the DC-removing path, plain integer arithmetic.
   task automatic dc_model(input int c, output int s);
      int dc, y;
      dc   = dc_m >>> 6;
      y    = c - dc;
      dc_m = dc_m + y;
      s    = y >>> 4;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
   endtask

   // e1 = 999 takes the dut1 expectation from the reference model.
   task automatic drive(input int d, input bit last, input int x0, input int x1);
      int c, m;
      @(posedge clk_in); #1;
      mic_valid_in = 1'b1;
      mic_data_in  = 12'(d);
      fsum += d;
      if (last) begin
         c    = (fsum >>> 2) - 2048;
         fsum = 0;
         dc_model(c, m);
         q0.push_back('{x0, cyc + 2});
         q1.push_back('{(x1 == 999) ? m : x1, cyc + 2});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in); #1;
         mic_valid_in = 1'b0;
      end
   endtask

   task automatic frame4(input int d, input int x0, input int x1);
      for (int i = 0; i < 4; i++) begin
         drive(d, i == 3, x0, x1);
         idle(1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      fsum = 0;
      dc_m = 0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b0; mic_valid_in = 1'b0; mic_data_in = '0; record_req_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check("reset audio", int'(a0), 0);
      check("reset valid", int'(v0), 0);
      check("reset record", int'(r0), 0);
      check("reset full", int'(f0), 0);
      rst_in = 1'b1;

      // Full scale, zero, small positive and small negative offsets.
      frame4(12'hFFF, 127, 999);
      frame4(12'h000, -128, 999);
      drive(12'h800, 0, 0, 0); idle(1);
      drive(12'h810, 0, 0, 0); idle(1);
      drive(12'h820, 0, 0, 0); idle(1);
      drive(12'h830, 1, 1, 999); idle(1);
      frame4(12'h7F0, -1, 999);
      frame4(12'h7FF, -1, 999);
      idle(3);

      // Asynchronous reset with half a frame pending.
      record_req_in = 1'b1;
      drive(12'hFFF, 0, 0, 0); idle(1);
      drive(12'hFFF, 0, 0, 0); idle(2);
      check("record before reset", int'(r0), 1);
      #3;
      rst_in = 1'b0;
      fsum = 0;
      dc_m = 0;
      #1;
      check("async reset audio", int'(a0), 0);
      check("async reset valid", int'(v0), 0);
      check("async reset record", int'(r0), 0);
      check("async reset full", int'(f0), 0);
      record_req_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      frame4(12'h800, 0, 0);
      idle(2);

      // DC tracking on a constant input; dut1 decays toward zero.
      frame4(12'hA00, 32, 32);
      frame4(12'hA00, 32, 31);
      for (int f = 0; f < 1022; f++)
         for (int i = 0; i < 4; i++)
            drive(12'hA00, i == 3, 32, 999);
      idle(3);
      check("dc settled |audio|<=1", (($signed(a1) <= 1) && ($signed(a1) >= -1)) ? 1 : 0, 1);

      // Record gating with MAX_SAMPLES = 5.
      do_reset();
      record_req_in = 1'b1;
      idle(2);
      check("gate record initial", int'(r0), 1);
      for (int k = 1; k <= 7; k++) begin
         for (int i = 0; i < 4; i++)
            drive(12'h800, i == 3, 0, 0);
         @(posedge clk_in); #1;
         mic_valid_in = 1'b0;
         @(posedge clk_in);
         @(negedge clk_in);
         check($sformatf("gate strobe %0d record", k), int'(r0), (k <= 5) ? 1 : 0);
         check($sformatf("gate strobe %0d full", k), int'(f0), (k <= 5) ? 0 : 1);
         if (k == 5) begin
            @(negedge clk_in);
            check("gate after 5 record", int'(r0), 0);
            check("gate after 5 full", int'(f0), 1);
         end
         idle(1);
      end
      record_req_in = 1'b0;
      idle(3);
      check("full sticky dut0", int'(f0), 1);
      check("full sticky dut1", int'(f1), 1);
      check("record low after drop", int'(r0), 0);

      // Back-to-back valids for 12 cycles: three frames, four cycles apart.
      for (int i = 0; i < 4; i++) drive(12'h900, i == 3, 16, 999);
      for (int i = 0; i < 4; i++) drive(12'h700, i == 3, -16, 999);
      for (int i = 0; i < 4; i++) drive(12'h805, i == 3, 0, 999);
      idle(5);

      check("dut0 pending strobes", q0.size(), 0);
      check("dut1 pending strobes", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
